// File: rtl/m_axis_cq_tlp_split_if.sv
// m_axis_cq_tlp_split_if: legacy CQ request stream in, DW0-aligned payload stream out.
interface m_axis_cq_tlp_split_if #(
  parameter int DATA_WIDTH = 128,
  parameter int KEEP_WIDTH = DATA_WIDTH/8
);
  logic [DATA_WIDTH-1:0] s_tdata;
  logic [KEEP_WIDTH-1:0] s_tkeep;
  logic                  s_tlast;
  logic [84:0]           s_tuser;
  logic                  s_tvalid;
  logic                  s_tready;
  logic [DATA_WIDTH-1:0] m_tdata;
  logic [KEEP_WIDTH-1:0] m_tbe;
  logic                  m_tlast;
  logic                  m_tvalid;
  logic                  m_tready;
  modport slave (
    input  s_tdata, s_tkeep, s_tlast, s_tuser, s_tvalid, m_tready,
    output s_tready, m_tdata, m_tbe, m_tlast, m_tvalid
  );
  modport master (
    output s_tdata, s_tkeep, s_tlast, s_tuser, s_tvalid, m_tready,
    input  s_tready, m_tdata, m_tbe, m_tlast, m_tvalid
  );
endinterface

// File: rtl/m_axis_cq_tlp_split.sv
// m_axis_cq_tlp_split: decodes 3DW/4DW request headers and realigns payload so data DW0 sits in [31:0].
// Defining M_AXIS_CQ_TLP_SPLIT_ERR_CNT_EN adds a saturating framing-error counter (err_cnt, err_cnt_clr).
module m_axis_cq_tlp_split #(
  parameter int DATA_WIDTH = 128,
  parameter int KEEP_WIDTH = DATA_WIDTH/8
) (
  input  logic        user_clk,
  input  logic        user_reset_n,
  m_axis_cq_tlp_split_if.slave bus,
  output logic [2:0]  hdr_fmt,
  output logic [4:0]  hdr_type,
  output logic [2:0]  hdr_tc,
  output logic [1:0]  hdr_attr,
  output logic [9:0]  hdr_len,
  output logic [15:0] hdr_reqid,
  output logic [7:0]  hdr_tag,
  output logic [3:0]  hdr_first_be,
  output logic [3:0]  hdr_last_be,
  output logic [63:0] hdr_addr,
  output logic [7:0]  hdr_bar_hit,
  output logic        err_pulse
`ifdef M_AXIS_CQ_TLP_SPLIT_ERR_CNT_EN
  ,
  input  logic        err_cnt_clr,
  output logic [15:0] err_cnt
`endif
);
  typedef enum logic [2:0] {IDLE, DATA, RDONLY, LAST1, FLUSH, DROP} state_t;
  state_t state, state_n;
  logic [10:0] rem, rem_n, need;
  logic [31:0] residual, dw0, dw1;
  logic is4, drop_r, drop_n, adv, acc, emit, err, o_last, single;
  logic [DATA_WIDTH-1:0] o_data;
  logic [KEEP_WIDTH-1:0] o_be;
  logic unused;
  function automatic logic [15:0] be_of(input logic [10:0] n);
    return n >= 11'd4 ? 16'hFFFF : n == 11'd3 ? 16'h0FFF : n == 11'd2 ? 16'h00FF : n == 11'd1 ? 16'h000F : 16'h0000;
  endfunction
  assign dw0 = bus.s_tdata[31:0];
  assign dw1 = bus.s_tdata[63:32];
  assign unused = ^{bus.s_tuser[84:9], bus.s_tuser[0], dw0[23], dw0[19:14], dw0[11:10]};
  assign adv = !bus.m_tvalid || bus.m_tready;
  assign bus.s_tready = (state == IDLE || state == DATA) ? adv : state == DROP;
  assign acc = bus.s_tvalid && bus.s_tready;
  assign single = !dw0[30] || (!dw0[29] && dw0[9:0] == 10'd1);
  // DWs still owed by the input: a 3DW packet already parked one in the residual
  assign need = is4 ? rem : rem - 11'd1;
  always_comb begin
    state_n = state;
    rem_n = rem;
    drop_n = drop_r;
    emit = 1'b0;
    err = 1'b0;
    o_last = 1'b0;
    o_be = be_of(rem);
    o_data = {bus.s_tdata[95:0], residual};
    case (state)
      IDLE: if (acc) begin
        err = single ? !bus.s_tlast : bus.s_tlast;
        drop_n = single && !bus.s_tlast;
        rem_n = {~|dw0[9:0], dw0[9:0]};
        state_n = !dw0[30] ? RDONLY : single ? LAST1 : bus.s_tlast ? (dw0[29] ? RDONLY : FLUSH) : DATA;
      end
      DATA: if (acc) begin
        emit = 1'b1;
        o_data = is4 ? bus.s_tdata : o_data;
        rem_n = rem >= 11'd4 ? rem - 11'd4 : 11'd0;
        if (bus.s_tlast && need > 11'd4) begin
          err = 1'b1;
          o_last = 1'b1;
          o_be = is4 ? bus.s_tkeep : {bus.s_tkeep[11:0], 4'hF};
          state_n = IDLE;
        end else if (!is4 && rem == 11'd5) begin
          err = !bus.s_tlast;
          drop_n = !bus.s_tlast;
          state_n = FLUSH;
        end else if (need <= 11'd4) begin
          err = !bus.s_tlast;
          o_last = 1'b1;
          state_n = bus.s_tlast ? IDLE : DROP;
        end
      end
      RDONLY: if (adv) begin
        emit = 1'b1;
        o_last = 1'b1;
        o_be = '0;
        o_data = '0;
        state_n = drop_r ? DROP : IDLE;
      end
      LAST1, FLUSH: if (adv) begin
        emit = 1'b1;
        o_last = 1'b1;
        o_be = 16'h000F;
        o_data = '0;
        o_data[31:0] = residual;
        state_n = drop_r ? DROP : IDLE;
      end
      DROP: if (acc && bus.s_tlast) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge user_clk or negedge user_reset_n) begin
    if (!user_reset_n) begin
      state <= IDLE;
      rem <= '0;
      residual <= '0;
      is4 <= 1'b0;
      drop_r <= 1'b0;
      err_pulse <= 1'b0;
      bus.m_tvalid <= 1'b0;
      bus.m_tdata <= '0;
      bus.m_tbe <= '0;
      bus.m_tlast <= 1'b0;
      {hdr_fmt, hdr_type, hdr_tc, hdr_attr, hdr_len, hdr_reqid, hdr_tag} <= '0;
      {hdr_first_be, hdr_last_be, hdr_addr, hdr_bar_hit} <= '0;
    end else begin
      state <= state_n;
      rem <= rem_n;
      drop_r <= drop_n;
      err_pulse <= err;
      if (adv) bus.m_tvalid <= emit;
      if (adv && emit) begin
        bus.m_tdata <= o_data;
        bus.m_tbe <= o_be;
        bus.m_tlast <= o_last;
      end
      if (acc && (state == IDLE || state == DATA)) residual <= bus.s_tdata[127:96];
      if (acc && state == IDLE) begin
        is4 <= dw0[29];
        hdr_fmt <= dw0[31:29];
        hdr_type <= dw0[28:24];
        hdr_tc <= dw0[22:20];
        hdr_attr <= dw0[13:12];
        hdr_len <= dw0[9:0];
        hdr_reqid <= dw1[31:16];
        hdr_tag <= dw1[15:8];
        hdr_last_be <= dw1[7:4];
        hdr_first_be <= dw1[3:0];
        hdr_addr <= dw0[29] ? {bus.s_tdata[95:64], bus.s_tdata[127:96]} : {32'd0, bus.s_tdata[95:64]};
        hdr_bar_hit <= bus.s_tuser[8:1];
      end
    end
  end
`ifdef M_AXIS_CQ_TLP_SPLIT_ERR_CNT_EN
  always_ff @(posedge user_clk or negedge user_reset_n) begin
    if (!user_reset_n) err_cnt <= '0;
    else if (err_cnt_clr) err_cnt <= '0;
    else if (err_pulse && err_cnt != 16'hFFFF) err_cnt <= err_cnt + 16'd1;
  end
`endif
endmodule

// File: tb/tb_m_axis_cq_tlp_split.sv
// tb_m_axis_cq_tlp_split: directed scenarios for the CQ TLP splitter with hand-computed expectations.
module tb_m_axis_cq_tlp_split;
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;
  m_axis_cq_tlp_split_if bus ();
  logic [2:0]  hdr_fmt, hdr_tc;
  logic [4:0]  hdr_type;
  logic [1:0]  hdr_attr;
  logic [9:0]  hdr_len;
  logic [15:0] hdr_reqid;
  logic [7:0]  hdr_tag, hdr_bar_hit;
  logic [3:0]  hdr_first_be, hdr_last_be;
  logic [63:0] hdr_addr;
  logic        err_pulse;
`ifdef M_AXIS_CQ_TLP_SPLIT_ERR_CNT_EN
  logic        err_cnt_clr = 1'b0;
  logic [15:0] err_cnt;
`endif
  m_axis_cq_tlp_split dut (
    .user_clk(clk), .user_reset_n(rst_n), .bus(bus),
    .hdr_fmt(hdr_fmt), .hdr_type(hdr_type), .hdr_tc(hdr_tc), .hdr_attr(hdr_attr),
    .hdr_len(hdr_len), .hdr_reqid(hdr_reqid), .hdr_tag(hdr_tag),
    .hdr_first_be(hdr_first_be), .hdr_last_be(hdr_last_be), .hdr_addr(hdr_addr),
    .hdr_bar_hit(hdr_bar_hit), .err_pulse(err_pulse)
`ifdef M_AXIS_CQ_TLP_SPLIT_ERR_CNT_EN
    , .err_cnt_clr(err_cnt_clr), .err_cnt(err_cnt)
`endif
  );
  typedef struct {logic [127:0] d; logic [15:0] be; logic l;} beat_t;
  beat_t q[$];
  int checks = 0, errors = 0, errp = 0, stall_bad = 0;
  always @(negedge clk) begin
    if (bus.m_tvalid && bus.m_tready) q.push_back('{bus.m_tdata, bus.m_tbe, bus.m_tlast});
    if (err_pulse) errp++;
    if (bus.m_tvalid && !bus.m_tready && bus.s_tready) stall_bad++;
  end
  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t (need finish)", $time);
    $fatal(1);
  end
  function automatic logic [31:0] dw(input int i);
    return 32'hC0DE_0000 | 32'(i);
  endfunction
  function automatic logic [63:0] h01(input logic [2:0] fmt, input logic [9:0] len, input logic [7:0] tag);
    return {16'hABCD, tag, 4'hF, 4'hF, fmt, 5'd0, 1'b0, 3'd5, 6'd0, 2'b10, 2'd0, len};
  endfunction
  task automatic send(input logic [127:0] d, input logic [15:0] k, input logic l);
    int t = 0;
    bus.s_tdata = d;
    bus.s_tkeep = k;
    bus.s_tlast = l;
    bus.s_tvalid = 1'b1;
    @(negedge clk);
    while (!bus.s_tready && t < 40) begin @(negedge clk); t++; end
    if (!bus.s_tready) begin
      checks++; errors++;
      $display("FAIL send_timeout: s_tready=0 after %0d cycles (need 1)", t);
    end
    @(posedge clk); #1;
    bus.s_tvalid = 1'b0;
  endtask
  task automatic drain(input int n);
    for (int i = 0; i < 40 && q.size() < n; i++) @(negedge clk);
    repeat (3) @(negedge clk);
    @(posedge clk); #1;
  endtask
  task automatic test_reset;
    rst_n = 1'b0;
    bus.m_tready = 1'b1;
    bus.s_tvalid = 1'b0;
    bus.s_tdata = '0;
    bus.s_tkeep = '0;
    bus.s_tlast = 1'b0;
    bus.s_tuser = '0;
    repeat (3) @(negedge clk);
    checks++; if (bus.m_tvalid !== 1'b0 || bus.m_tlast !== 1'b0) begin errors++;
      $display("FAIL reset_valid: m_tvalid=%b m_tlast=%b (need 0 0)", bus.m_tvalid, bus.m_tlast); end
    checks++; if (err_pulse !== 1'b0) begin errors++;
      $display("FAIL reset_err: err_pulse=%b (need 0)", err_pulse); end
    checks++; if (hdr_addr !== 64'd0 || hdr_tag !== 8'd0 || hdr_len !== 10'd0 || hdr_fmt !== 3'd0) begin errors++;
      $display("FAIL reset_hdr: addr=%h tag=%h len=%h fmt=%h (need 0)", hdr_addr, hdr_tag, hdr_len, hdr_fmt); end
    checks++; if (bus.m_tdata !== 128'd0 || bus.m_tbe !== 16'd0) begin errors++;
      $display("FAIL reset_data: m_tdata=%h m_tbe=%h (need 0)", bus.m_tdata, bus.m_tbe); end
    checks++; if (bus.s_tready !== 1'b1) begin errors++;
      $display("FAIL reset_ready: s_tready=%b (need 1)", bus.s_tready); end
`ifdef M_AXIS_CQ_TLP_SPLIT_ERR_CNT_EN
    checks++; if (err_cnt !== 16'd0) begin errors++;
      $display("FAIL reset_errcnt: err_cnt=%h (need 0)", err_cnt); end
`endif
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask
  task automatic test_mrd;
    int e0 = errp;
    q.delete();
    bus.s_tuser = {76'd0, 8'h04, 1'b0};
    send({32'h0, 32'h0000_1000, h01(3'b000, 10'd1, 8'h12)}, 16'h0FFF, 1'b1);
    drain(1);
    checks++; if (q.size() != 1 || q[0].be !== 16'h0000 || q[0].l !== 1'b1) begin errors++;
      $display("FAIL mrd_beat: beats=%0d be=%h last=%b (need 1 0000 1)", q.size(), q[0].be, q[0].l); end
    checks++; if (hdr_addr !== 64'h1000 || hdr_tag !== 8'h12 || hdr_len !== 10'd1 || hdr_bar_hit !== 8'h04) begin errors++;
      $display("FAIL mrd_hdr: addr=%h tag=%h len=%0d bar=%h (need 1000 12 1 04)", hdr_addr, hdr_tag, hdr_len, hdr_bar_hit); end
    checks++; if (hdr_reqid !== 16'hABCD || hdr_tc !== 3'd5 || hdr_attr !== 2'b10 || hdr_first_be !== 4'hF || hdr_fmt !== 3'b000) begin errors++;
      $display("FAIL mrd_fields: reqid=%h tc=%0d attr=%b fbe=%h fmt=%b (need abcd 5 10 f 000)", hdr_reqid, hdr_tc, hdr_attr, hdr_first_be, hdr_fmt); end
    checks++; if (errp != e0) begin errors++;
      $display("FAIL mrd_err: err pulses=%0d (need 0)", errp - e0); end
  endtask
  task automatic test_last1;
    int e0 = errp;
    q.delete();
    send({32'hDEADBEEF, 32'h2000, h01(3'b010, 10'd1, 8'h21)}, 16'hFFFF, 1'b1);
    drain(1);
    checks++; if (q.size() != 1 || q[0].d !== 128'hDEADBEEF || q[0].be !== 16'h000F || q[0].l !== 1'b1) begin errors++;
      $display("FAIL last1_beat: beats=%0d d=%h be=%h last=%b (need 1 deadbeef 000f 1)", q.size(), q[0].d, q[0].be, q[0].l); end
    checks++; if (hdr_fmt !== 3'b010 || hdr_addr !== 64'h2000 || errp != e0) begin errors++;
      $display("FAIL last1_hdr: fmt=%b addr=%h errs=%0d (need 010 2000 0)", hdr_fmt, hdr_addr, errp - e0); end
  endtask
  task automatic test_data3;
    int e0 = errp;
    q.delete();
    send({dw(0), 32'h3000, h01(3'b010, 10'd6, 8'h30)}, 16'hFFFF, 1'b0);
    send({dw(4), dw(3), dw(2), dw(1)}, 16'hFFFF, 1'b0);
    send({96'd0, dw(5)}, 16'h000F, 1'b1);
    drain(2);
    checks++; if (q.size() != 2) begin errors++;
      $display("FAIL data3_count: beats=%0d (need 2)", q.size()); end
    checks++; if (q[0].d !== {dw(3), dw(2), dw(1), dw(0)} || q[0].be !== 16'hFFFF || q[0].l !== 1'b0) begin errors++;
      $display("FAIL data3_a: d=%h be=%h last=%b (need D3..D0 ffff 0)", q[0].d, q[0].be, q[0].l); end
    checks++; if (q[1].d[63:0] !== {dw(5), dw(4)} || q[1].be !== 16'h00FF || q[1].l !== 1'b1) begin errors++;
      $display("FAIL data3_b: d=%h be=%h last=%b (need D5,D4 00ff 1)", q[1].d, q[1].be, q[1].l); end
    checks++; if (errp != e0) begin errors++;
      $display("FAIL data3_err: err pulses=%0d (need 0)", errp - e0); end
  endtask
  task automatic test_data4;
    q.delete();
    send({32'h2345_6780, 32'h0000_0001, h01(3'b011, 10'd4, 8'h40)}, 16'hFFFF, 1'b0);
    send({dw(3), dw(2), dw(1), dw(0)}, 16'hFFFF, 1'b1);
    drain(1);
    checks++; if (hdr_addr !== 64'h0000_0001_2345_6780) begin errors++;
      $display("FAIL data4_addr: addr=%h (need 0000000123456780)", hdr_addr); end
    checks++; if (q.size() != 1 || q[0].d !== {dw(3), dw(2), dw(1), dw(0)} || q[0].be !== 16'hFFFF || q[0].l !== 1'b1) begin errors++;
      $display("FAIL data4_beat: beats=%0d d=%h be=%h last=%b (need 1 D3..D0 ffff 1)", q.size(), q[0].d, q[0].be, q[0].l); end
  endtask
  task automatic test_flush;
    int e0 = errp;
    q.delete();
    send({dw(0), 32'h4000, h01(3'b010, 10'd5, 8'h45)}, 16'hFFFF, 1'b0);
    send({dw(4), dw(3), dw(2), dw(1)}, 16'hFFFF, 1'b1);
    drain(2);
    checks++; if (q.size() != 2 || q[0].d !== {dw(3), dw(2), dw(1), dw(0)} || q[0].be !== 16'hFFFF || q[0].l !== 1'b0) begin errors++;
      $display("FAIL flush_a: beats=%0d d=%h be=%h last=%b (need 2 D3..D0 ffff 0)", q.size(), q[0].d, q[0].be, q[0].l); end
    checks++; if (q[1].d !== {96'd0, dw(4)} || q[1].be !== 16'h000F || q[1].l !== 1'b1) begin errors++;
      $display("FAIL flush_b: d=%h be=%h last=%b (need D4 000f 1)", q[1].d, q[1].be, q[1].l); end
    checks++; if (errp != e0) begin errors++;
      $display("FAIL flush_err: err pulses=%0d (need 0)", errp - e0); end
  endtask
  task automatic test_trunc;
    int e0 = errp;
    q.delete();
    send({dw(0), 32'h5000, h01(3'b010, 10'd8, 8'h50)}, 16'hFFFF, 1'b0);
    send({dw(4), dw(3), dw(2), dw(1)}, 16'hFFFF, 1'b1);
    send({32'h0, 32'h0000_6000, h01(3'b000, 10'd1, 8'h34)}, 16'h0FFF, 1'b1);
    drain(2);
    checks++; if (q.size() != 2 || q[0].d !== {dw(3), dw(2), dw(1), dw(0)} || q[0].be !== 16'hFFFF || q[0].l !== 1'b1) begin errors++;
      $display("FAIL trunc_beat: beats=%0d d=%h be=%h last=%b (need 2 D3..D0 ffff 1)", q.size(), q[0].d, q[0].be, q[0].l); end
    checks++; if (errp - e0 != 1) begin errors++;
      $display("FAIL trunc_err: err pulse cycles=%0d (need 1)", errp - e0); end
    checks++; if (q[1].be !== 16'h0000 || q[1].l !== 1'b1 || hdr_tag !== 8'h34 || hdr_addr !== 64'h6000) begin errors++;
      $display("FAIL trunc_next: be=%h last=%b tag=%h addr=%h (need 0000 1 34 6000)", q[1].be, q[1].l, hdr_tag, hdr_addr); end
  endtask
  task automatic test_drop;
    int e0 = errp;
    q.delete();
    send({32'h10, 32'h0, h01(3'b011, 10'd2, 8'h50)}, 16'hFFFF, 1'b0);
    send({64'd0, dw(1), dw(0)}, 16'h00FF, 1'b0);
    send({dw(9), dw(8), dw(7), dw(6)}, 16'hFFFF, 1'b1);
    send({32'h0, 32'h0000_7000, h01(3'b000, 10'd1, 8'h51)}, 16'h0FFF, 1'b1);
    drain(2);
    checks++; if (q.size() != 2 || q[0].d[63:0] !== {dw(1), dw(0)} || q[0].be !== 16'h00FF || q[0].l !== 1'b1) begin errors++;
      $display("FAIL drop_beat: beats=%0d d=%h be=%h last=%b (need 2 D1,D0 00ff 1)", q.size(), q[0].d, q[0].be, q[0].l); end
    checks++; if (errp - e0 != 1) begin errors++;
      $display("FAIL drop_err: err pulse cycles=%0d (need 1)", errp - e0); end
    checks++; if (q[1].be !== 16'h0000 || q[1].l !== 1'b1 || hdr_tag !== 8'h51) begin errors++;
      $display("FAIL drop_next: be=%h last=%b tag=%h (need 0000 1 51)", q[1].be, q[1].l, hdr_tag); end
  endtask
  task automatic test_backpressure;
    int e0 = errp;
    int s0 = stall_bad;
    q.delete();
    fork
      begin
        send({dw(0), 32'h8000, h01(3'b010, 10'd16, 8'h60)}, 16'hFFFF, 1'b0);
        for (int b = 0; b < 3; b++) send({dw(4*b+4), dw(4*b+3), dw(4*b+2), dw(4*b+1)}, 16'hFFFF, 1'b0);
        send({32'h0, dw(15), dw(14), dw(13)}, 16'h0FFF, 1'b1);
      end
      for (int i = 0; i < 40; i++) begin @(posedge clk); #1; bus.m_tready = ~bus.m_tready; end
    join
    bus.m_tready = 1'b1;
    drain(4);
    checks++; if (q.size() != 4) begin errors++;
      $display("FAIL bp_count: beats=%0d (need 4)", q.size()); end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (q[i].d !== {dw(4*i+3), dw(4*i+2), dw(4*i+1), dw(4*i)} || q[i].be !== 16'hFFFF || q[i].l !== (i == 3)) begin errors++;
        $display("FAIL bp_beat%0d: d=%h be=%h last=%b (need D%0d..D%0d ffff %b)", i, q[i].d, q[i].be, q[i].l, 4*i+3, 4*i, i == 3); end
    end
    checks++; if (stall_bad != s0 || errp != e0) begin errors++;
      $display("FAIL bp_stall: ready-while-stalled cycles=%0d errs=%0d (need 0 0)", stall_bad - s0, errp - e0); end
  endtask
  task automatic test_back_to_back;
    q.delete();
    send({32'hA1A1_A1A1, 32'h9000, h01(3'b010, 10'd1, 8'h70)}, 16'hFFFF, 1'b1);
    send({32'h0, 32'h9100, h01(3'b000, 10'd1, 8'h71)}, 16'h0FFF, 1'b1);
    send({32'h0, 32'h9200, h01(3'b011, 10'd1, 8'h72)}, 16'hFFFF, 1'b0);
    send({96'd0, dw(0)}, 16'h000F, 1'b1);
    drain(3);
    checks++; if (q.size() != 3 || q[0].d !== 128'hA1A1_A1A1 || q[0].be !== 16'h000F || q[0].l !== 1'b1) begin errors++;
      $display("FAIL b2b_a: beats=%0d d=%h be=%h last=%b (need 3 a1a1a1a1 000f 1)", q.size(), q[0].d, q[0].be, q[0].l); end
    checks++; if (q[1].be !== 16'h0000 || q[1].l !== 1'b1) begin errors++;
      $display("FAIL b2b_b: be=%h last=%b (need 0000 1)", q[1].be, q[1].l); end
    checks++; if (q[2].d !== {96'd0, dw(0)} || q[2].be !== 16'h000F || q[2].l !== 1'b1 || hdr_tag !== 8'h72) begin errors++;
      $display("FAIL b2b_c: d=%h be=%h last=%b tag=%h (need D0 000f 1 72)", q[2].d, q[2].be, q[2].l, hdr_tag); end
  endtask
  initial begin
    test_reset();
    test_mrd();
    test_last1();
    test_data3();
    test_data4();
    test_flush();
    test_trunc();
    test_drop();
    test_backpressure();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/m_axis_cq_tlp_split.md
Name: m_axis_cq_tlp_split

Overview:
- Sits directly downstream of the CQ adapter, on the 128-bit legacy-format request TLP stream.
- Parses the 3DW/4DW header into stable sideband fields.
- Realigns payload so data DW0 always lands in bits [31:0], with per-byte enables.
- Feeds the LitePCIe request depacketizer/crossbar; checks framing against the header length.

Parameters:
- DATA_WIDTH, 128, stream width; only 128 is supported.
- KEEP_WIDTH, DATA_WIDTH/8, byte-keep width.

Ports:
- user_clk  in  1  clock.
- user_reset_n  in  1  asynchronous active-low reset.
- s_tdata  in  128  legacy TLP beat; DW0 = bits [31:0].
- s_tkeep  in  16  byte keep.
- s_tlast  in  1  end of TLP.
- s_tuser  in  85  sideband; bar_hit = s_tuser[8:1], sampled on header beat.
- s_tvalid  in  1  beat valid.
- s_tready  out  1  beat accepted when s_tvalid & s_tready.
- hdr_fmt  out  3  fmt.
- hdr_type  out  5  type.
- hdr_tc  out  3  traffic class.
- hdr_attr  out  2  attributes.
- hdr_len  out  10  DW length; 0 means 1024.
- hdr_reqid  out  16  requester ID.
- hdr_tag  out  8  tag.
- hdr_first_be  out  4  first DW byte enables.
- hdr_last_be  out  4  last DW byte enables.
- hdr_addr  out  64  address; [63:32]=0 for 3DW header.
- hdr_bar_hit  out  8  BAR hit.
- m_tdata  out  128  realigned payload.
- m_tbe  out  16  byte valid for m_tdata.
- m_tlast  out  1  last beat of TLP.
- m_tvalid  out  1  output valid.
- m_tready  in  1  downstream ready.
- err_pulse  out  1  one-cycle framing-error strobe.

Behaviour:
- Reset (async assert, sync release): state IDLE; m_tvalid=0, m_tlast=0, err_pulse=0; all hdr_* = 0; m_tdata=0, m_tbe=0.
- Header decode on the IDLE accepted beat:
  - DW0 = {fmt[31:29], type[28:24], tc[22:20], attr[13:12], len[9:0]}.
  - DW1 = {reqid[31:16], tag[15:8], last_be[7:4], first_be[3:0]}.
  - 4DW header (fmt[0]=1): addr = {DW2, DW3}.
  - 3DW header: addr = {32'b0, DW2}.
  - has_data = fmt[1].
  - All hdr_* are registered there and held stable until the next header beat is accepted.
- rem counter: 11 bits, loaded with len (0 -> 1024), decremented by the DWs emitted per output beat (4, or rem if rem<4).
- States:
  - IDLE: waits for a header beat. Next state:
    - no data -> RDONLY;
    - 3DW & len==1 -> LAST1;
    - otherwise -> DATA. 3DW holds DW3 in the residual register.
  - RDONLY: one output beat, m_tbe=0, m_tlast=1; hdr valid. -> IDLE on m_tready.
  - LAST1: one output beat {96'b0, held DW3}, m_tbe=0x000F, m_tlast=1. -> IDLE on m_tready.
  - DATA:
    - 3DW: output = {s_tdata[95:0], residual}; residual <= s_tdata[127:96].
    - 4DW: output = s_tdata.
    - m_tbe = all ones, except the beat where rem<=4: low rem*4 bits set.
    - m_tlast=1 when rem<=4.
    - If rem<=4 is reached and is satisfied by residual alone (3DW, rem==1 after an input tlast beat) -> FLUSH.
  - FLUSH: emits {96'b0, residual}, m_tbe=0x000F, m_tlast=1 (no input consumed). -> IDLE.
  - DROP: s_tready=1; discards beats until s_tlast. -> IDLE.
- Handshake:
  - s_tready = (!m_tvalid | m_tready) in IDLE/DATA; 0 in RDONLY/LAST1/FLUSH.
  - m_tvalid/m_tdata are registered (one output slice).
  - Latency: input beat to output 1 cycle. 4DW first data appears 1 cycle after beat1 accepted.
  - Back-to-back TLPs with no bubble when m_tready stays 1, except FLUSH/RDONLY/LAST1 beats.
- Framing errors (err_pulse for 1 cycle):
  - s_tlast arrives while rem>4 after the beat: emit that beat with m_tlast=1, m_tbe per actually received DWs -> IDLE.
  - rem reaches 0 without s_tlast: emit m_tlast normally -> DROP.
  - Both cases with simultaneous m_tready=0: output is held; the error is still flagged once.
- Reset mid-packet: everything returns to IDLE; a partial output beat is discarded.

Optional Feature:
- Macro: M_AXIS_CQ_TLP_SPLIT_ERR_CNT_EN.
- With it:
  - Adds output err_cnt[15:0], a saturating count of err_pulse events (sticks at 0xFFFF).
  - Adds input err_cnt_clr, which synchronously zeroes the count; clr wins over a same-cycle increment.
  - Reset value is 0.
- Without it: neither port exists; err_pulse only.

Test Plan:
- 3DW MRd (fmt=000, len=1, tag=0x12, addr DW2=0x00001000) -> one beat, m_tlast=1, m_tbe=0x0000, hdr_addr=0x1000, hdr_tag=0x12.
- 3DW MWr len=1, DW3=0xDEADBEEF -> LAST1 beat m_tdata[31:0]=0xDEADBEEF, m_tbe=0x000F, 1 cycle after header.
- 3DW MWr len=6, data D0..D5 over 3 input beats -> beat A = D3..D0 (m_tbe 0xFFFF); beat B = D5,D4 (m_tbe 0x00FF, m_tlast=1); err_pulse stays 0.
- 4DW MWr len=4, addr 0x1_2345_6780 -> hdr_addr=0x0000000123456780; one data beat, m_tbe=0xFFFF, m_tlast=1.
- MWr len=8 with s_tlast on the 2nd beat -> truncated output beat with m_tlast=1 and err_pulse=1 for 1 cycle; next TLP parses correctly.
- m_tready toggled 1010… during len=16 3DW write -> no DW lost or duplicated; s_tready low whenever the output slice is full and stalled.
